// File: rtl/tvc_cas_loader_if.sv
// Bus bundle between data_io / RAM write port and the CAS loader.
// master = loader side, slave = download source and RAM side.
interface tvc_cas_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_clkref;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_clkref, mem_req, mem_addr, mem_din
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_clkref, mem_req, mem_addr, mem_din
    );
endinterface

// File: rtl/tvc_cas_loader.sv
// CAS download loader: strips CAS headers, captures program length and writes
// the program body into TVC RAM one byte at a time, throttling data_io.
module tvc_cas_loader #(
    parameter logic [7:0]  CAS_IDX   = 8'd1,
    parameter logic [24:0] LEN_OFS   = 25'h82,
    parameter logic [24:0] DATA_OFS  = 25'h90,
    parameter logic [15:0] LOAD_BASE = 16'h19EF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    tvc_cas_loader_if.master        bus,
    output logic [15:0]             prg_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WACK, FINISH} state_t;

    state_t      state, state_nxt;
    logic        dl_q;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] prg_len_nxt, mem_addr_r, mem_addr_nxt;
    logic [7:0]  mem_din_r, mem_din_nxt;
    logic        clkref_r, clkref_nxt, mem_req_r, mem_req_nxt;
    logic        busy_nxt, done_nxt, err_nxt;
    logic        take;

    assign bus.ioctl_clkref = clkref_r;
    assign bus.mem_req      = mem_req_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_din      = mem_din_r;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            cnt        <= '0;
            prg_len    <= '0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            clkref_r   <= 1'b1;
            mem_req_r  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            dl_q       <= bus.ioctl_download;
            cnt        <= cnt_nxt;
            prg_len    <= prg_len_nxt;
            mem_addr_r <= mem_addr_nxt;
            mem_din_r  <= mem_din_nxt;
            clkref_r   <= clkref_nxt;
            mem_req_r  <= mem_req_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        prg_len_nxt  = prg_len;
        mem_addr_nxt = mem_addr_r;
        mem_din_nxt  = mem_din_r;
        clkref_nxt   = clkref_r;
        mem_req_nxt  = mem_req_r;
        busy_nxt     = busy;
        done_nxt     = done;
        err_nxt      = err;
        take         = 1'b0;

        case (state)
            IDLE: begin
                // Index is only looked at on the download's rising edge.
                if (bus.ioctl_download && !dl_q && bus.ioctl_index == CAS_IDX) begin
                    state_nxt   = HDR;
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    err_nxt     = 1'b0;
                    prg_len_nxt = '0;
                    cnt_nxt     = '0;
                end
            end
            HDR: begin
                if (!bus.ioctl_download) begin
                    state_nxt = FINISH;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_addr == LEN_OFS) begin
                        prg_len_nxt[7:0] = bus.ioctl_dout;
                    end else if (bus.ioctl_addr == LEN_OFS + 25'd1) begin
                        prg_len_nxt[15:8] = bus.ioctl_dout;
                    end else if (bus.ioctl_addr == DATA_OFS) begin
                        state_nxt = DATA;
                        take      = (cnt < prg_len);
                    end
                end
            end
            DATA: begin
                if (!bus.ioctl_download) begin
                    state_nxt = FINISH;
                end else if (bus.ioctl_wr) begin
                    take = (cnt < prg_len);
                end
            end
            WACK: begin
                if (bus.ioctl_wr) begin
                    err_nxt = 1'b1;
                end
                // A pending write always completes, even after the download ended.
                if (bus.mem_ack) begin
                    mem_req_nxt = 1'b0;
                    clkref_nxt  = 1'b1;
                    cnt_nxt     = cnt + 16'd1;
                    state_nxt   = bus.ioctl_download ? DATA : FINISH;
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                if (cnt == prg_len && !err) begin
                    done_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            mem_din_nxt  = bus.ioctl_dout;
            mem_addr_nxt = LOAD_BASE + cnt;
            mem_req_nxt  = 1'b1;
            clkref_nxt   = 1'b0;
            state_nxt    = WACK;
        end
    end

endmodule

// File: tb/tb_tvc_cas_loader.sv
// Directed bench for tvc_cas_loader: two instances (default and high LOAD_BASE)
// share the download stream; each has its own RAM ack responder and write log.
module tb_tvc_cas_loader;

    localparam int DATA_OFS = 'h90;
    localparam int LEN_OFS  = 'h82;
    localparam int ACK_DLY  = 2;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    tvc_cas_loader_if if0 ();
    tvc_cas_loader_if if1 ();

    assign if1.ioctl_download = if0.ioctl_download;
    assign if1.ioctl_index    = if0.ioctl_index;
    assign if1.ioctl_wr       = if0.ioctl_wr;
    assign if1.ioctl_addr     = if0.ioctl_addr;
    assign if1.ioctl_dout     = if0.ioctl_dout;

    logic [15:0] len0, len1;
    logic        busy0, busy1, done0, done1, err0, err1;

    tvc_cas_loader u0 (
        .clk_sys(clk), .reset(reset), .bus(if0.master),
        .prg_len(len0), .busy(busy0), .done(done0), .err(err0)
    );

    tvc_cas_loader #(.LOAD_BASE(16'hFFF0)) u1 (
        .clk_sys(clk), .reset(reset), .bus(if1.master),
        .prg_len(len1), .busy(busy1), .done(done1), .err(err1)
    );

    int nvec = 0;
    int nmis = 0;
    logic [23:0] wq0[$];
    logic [23:0] wq1[$];
    bit ack_en;
    bit bseen, cseen;
    int rc0, rc1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bval(input int i);
        return 8'(32'hAA + 32'h11 * i);
    endfunction

    // RAM side: ack ACK_DLY cycles after mem_req, logging {addr, data}.
    initial begin
        rc0 = 0; rc1 = 0;
        if0.mem_ack = 1'b0;
        if1.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rc0 = 0; if0.mem_ack = 1'b0;
            end else if (if0.mem_ack) begin
                if0.mem_ack = 1'b0;
            end else if (if0.mem_req && ack_en) begin
                rc0++;
                if (rc0 == ACK_DLY) begin
                    rc0 = 0; if0.mem_ack = 1'b1;
                    wq0.push_back({if0.mem_addr, if0.mem_din});
                end
            end
            if (reset) begin
                rc1 = 0; if1.mem_ack = 1'b0;
            end else if (if1.mem_ack) begin
                if1.mem_ack = 1'b0;
            end else if (if1.mem_req && ack_en) begin
                rc1++;
                if (rc1 == ACK_DLY) begin
                    rc1 = 0; if1.mem_ack = 1'b1;
                    wq1.push_back({if1.mem_addr, if1.mem_din});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy0) bseen = 1'b1;
            if (!if0.ioctl_clkref) cseen = 1'b1;
        end
    end

    task automatic wait_clkref();
        int t;
        t = 0;
        while (!if0.ioctl_clkref && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!if0.ioctl_clkref) begin
            nvec++; nmis++;
            $display("FAIL clkref_wait: got 0, expected 1 within 64 cycles");
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        wait_clkref();
        if0.ioctl_addr = 25'(a);
        if0.ioctl_dout = d;
        if0.ioctl_wr   = 1'b1;
        @(negedge clk);
        if0.ioctl_wr   = 1'b0;
    endtask

    task automatic send_cas(input logic [7:0] idx, input logic [15:0] len, input int nbody,
                            input int ovr, input bit fin);
        logic [7:0] d;
        int t;
        if0.ioctl_index    = idx;
        if0.ioctl_download = 1'b1;
        @(negedge clk);
        for (int a = 0; a < DATA_OFS + nbody; a++) begin
            d = 8'h00;
            if (a == LEN_OFS) d = len[7:0];
            else if (a == LEN_OFS + 1) d = len[15:8];
            else if (a >= DATA_OFS) d = bval(a - DATA_OFS);
            send_byte(a, d);
            if (ovr >= 0 && a == DATA_OFS + ovr) begin
                // Write strobe while the previous byte is still pending.
                if0.ioctl_addr = 25'(a + 1);
                if0.ioctl_dout = 8'h55;
                if0.ioctl_wr   = 1'b1;
                @(negedge clk);
                if0.ioctl_wr   = 1'b0;
            end
        end
        if (fin) begin
            wait_clkref();
            if0.ioctl_download = 1'b0;
            repeat (3) @(negedge clk);
            t = 0;
            while (busy0 && t < 32) begin
                @(negedge clk);
                t++;
            end
            if (busy0) begin
                nvec++; nmis++;
                $display("FAIL busy_wait: busy still 1 after download end");
            end
        end
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] len;
        int          nbody;
        int          ovr;
        int          exp_nw;
        logic [15:0] exp_len;
        logic        exp_done;
        logic        exp_err;
        logic        exp_busy;
    } vec_t;

    vec_t  vt[8];
    string vn[8];

    initial begin
        reset = 1'b1;
        ack_en = 1'b1;
        if0.ioctl_download = 1'b0;
        if0.ioctl_index    = 8'd0;
        if0.ioctl_wr       = 1'b0;
        if0.ioctl_addr     = '0;
        if0.ioctl_dout     = '0;
        repeat (3) @(negedge clk);

        chk("rst clkref", 32'(if0.ioctl_clkref), 32'd1);
        chk("rst mem_req", 32'(if0.mem_req), 32'd0);
        chk("rst mem_addr", 32'(if0.mem_addr), 32'd0);
        chk("rst mem_din", 32'(if0.mem_din), 32'd0);
        chk("rst prg_len", 32'(len0), 32'd0);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst err", 32'(err0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //                 idx    len       nbody ovr nw  exp_len  done  err   busy
        vt[0] = '{8'd0, 16'd3,    3,   -1, 0,  16'd0,    1'b0, 1'b0, 1'b0}; vn[0] = "rom";
        vt[1] = '{8'd1, 16'd3,    3,   -1, 3,  16'd3,    1'b1, 1'b0, 1'b1}; vn[1] = "basic";
        vt[2] = '{8'd1, 16'd3,    3,    0, 3,  16'd3,    1'b0, 1'b1, 1'b1}; vn[2] = "overrun";
        vt[3] = '{8'd1, 16'd5,    2,   -1, 2,  16'd5,    1'b0, 1'b1, 1'b1}; vn[3] = "trunc";
        vt[4] = '{8'd1, 16'd2,    4,   -1, 2,  16'd2,    1'b1, 1'b0, 1'b1}; vn[4] = "excess";
        vt[5] = '{8'd1, 16'd0,    2,   -1, 0,  16'd0,    1'b1, 1'b0, 1'b1}; vn[5] = "zerolen";
        vt[6] = '{8'd1, 16'd3,    0,   -1, 0,  16'd3,    1'b0, 1'b1, 1'b1}; vn[6] = "short";
        vt[7] = '{8'd1, 16'h20, 32,   -1, 32, 16'h20,   1'b1, 1'b0, 1'b1}; vn[7] = "wrap";

        for (int v = 0; v < 8; v++) begin
            wq0.delete();
            wq1.delete();
            bseen = 1'b0;
            cseen = 1'b0;
            send_cas(vt[v].idx, vt[v].len, vt[v].nbody, vt[v].ovr, 1'b1);
            chk({vn[v], " nwrites0"}, 32'(wq0.size()), 32'(vt[v].exp_nw));
            chk({vn[v], " nwrites1"}, 32'(wq1.size()), 32'(vt[v].exp_nw));
            for (int i = 0; i < vt[v].exp_nw && i < wq0.size() && i < wq1.size(); i++) begin
                chk($sformatf("%s w%0d addr0", vn[v], i), 32'(wq0[i][23:8]), 32'(16'(32'h19EF + i)));
                chk($sformatf("%s w%0d data0", vn[v], i), 32'(wq0[i][7:0]), 32'(bval(i)));
                chk($sformatf("%s w%0d addr1", vn[v], i), 32'(wq1[i][23:8]), 32'(16'(32'hFFF0 + i)));
            end
            chk({vn[v], " prg_len"}, 32'(len0), 32'(vt[v].exp_len));
            chk({vn[v], " done"}, 32'(done0), 32'(vt[v].exp_done));
            chk({vn[v], " err"}, 32'(err0), 32'(vt[v].exp_err));
            chk({vn[v], " err1"}, 32'(err1), 32'(vt[v].exp_err));
            chk({vn[v], " busy_end"}, 32'(busy0), 32'd0);
            chk({vn[v], " busy_seen"}, 32'(bseen), 32'(vt[v].exp_busy));
            chk({vn[v], " clkref_low_seen"}, 32'(cseen), 32'(vt[v].exp_nw > 0));
        end

        // Wrap spot checks on the high-base instance (last table entry).
        if (wq1.size() == 32) begin
            chk("wrap w15 addr1", 32'(wq1[15][23:8]), 32'h0000FFFF);
            chk("wrap w16 addr1", 32'(wq1[16][23:8]), 32'h00000000);
            chk("wrap w31 addr1", 32'(wq1[31][23:8]), 32'h0000000F);
        end else begin
            chk("wrap log size", 32'(wq1.size()), 32'd32);
        end

        // Latency: ioctl_wr at DATA_OFS -> mem_req one cycle later, clkref drops.
        ack_en = 1'b0;
        wq0.delete();
        send_cas(8'd1, 16'd3, 1, -1, 1'b0);
        chk("lat mem_req", 32'(if0.mem_req), 32'd1);
        chk("lat clkref", 32'(if0.ioctl_clkref), 32'd0);
        chk("lat mem_addr", 32'(if0.mem_addr), 32'h19EF);
        chk("lat mem_din", 32'(if0.mem_din), 32'hAA);
        chk("lat busy", 32'(busy0), 32'd1);
        repeat (4) @(negedge clk);
        chk("hold mem_req", 32'(if0.mem_req), 32'd1);

        // Reset while a write is pending drops it without an ack.
        reset = 1'b1;
        if0.ioctl_download = 1'b0;
        @(negedge clk);
        chk("midrst mem_req", 32'(if0.mem_req), 32'd0);
        chk("midrst busy", 32'(busy0), 32'd0);
        chk("midrst clkref", 32'(if0.ioctl_clkref), 32'd1);
        chk("midrst prg_len", 32'(len0), 32'd0);
        chk("midrst nwrites", 32'(wq0.size()), 32'd0);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);

        // Loader recovers and runs a clean load after the reset.
        wq0.delete();
        send_cas(8'd1, 16'd1, 1, -1, 1'b1);
        chk("post nwrites", 32'(wq0.size()), 32'd1);
        chk("post done", 32'(done0), 32'd1);
        chk("post err", 32'(err0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
